// File: rtl/sine_pkg.sv
// Shared constants and state encoding for the sine sample generator and its LUT.
package sine_pkg;

    localparam int DATA_W       = 10;
    localparam int MID          = 512;
    localparam int AMP_W        = 9;
    localparam int PRIME_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine amplitude ROM with a registered read port (one cycle latency).
// Entry k holds round(511*sin(pi/2*(k+0.5)/64)), so the table never reaches zero.
module sine_quarter_lut
    import sine_pkg::*;
#(
    parameter int LUT_ADDR_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [LUT_ADDR_W-1:0] i_addr,
    output logic [AMP_W-1:0]      o_amp
);

    localparam logic [AMP_W-1:0] ROM [64] = '{
          6,  19,  31,  44,  56,  69,  81,  94,
        106, 118, 130, 142, 154, 166, 178, 190,
        201, 213, 224, 235, 246, 257, 268, 279,
        289, 299, 309, 319, 329, 338, 348, 357,
        366, 374, 383, 391, 399, 407, 414, 421,
        428, 435, 441, 448, 454, 459, 465, 470,
        474, 479, 483, 487, 491, 494, 497, 500,
        502, 505, 506, 508, 509, 510, 511, 511
    };

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_amp <= '0;
        end else begin
            o_amp <= ROM[i_addr];
        end
    end

endmodule

// File: rtl/sine_sample_gen.sv
// Phase-accumulator sine source feeding the PWM stage; each sample is held for
// exactly one PWM period so the duty value only changes at the counter wrap.
module sine_sample_gen #(
    parameter int DATA_W     = 10,
    parameter int PHASE_W    = 16,
    parameter int LUT_ADDR_W = 6,
    parameter int PERIOD_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] tune_word,
    output logic [DATA_W-1:0]  out_val,
    output logic               valid,
    output logic               sample_strobe
);
    import sine_pkg::*;

    localparam int                SEL_W      = LUT_ADDR_W + 2;
    localparam logic [DATA_W-1:0] MID_HI     = DATA_W'(MID);
    localparam logic [DATA_W-1:0] MID_LO     = DATA_W'(MID - 1);
    localparam logic [1:0]        PRIME_LAST = 2'(PRIME_CYCLES - 1);

    state_t                r_state;
    logic [1:0]            r_primeCnt;
    logic [PERIOD_W-1:0]   r_pcnt;
    logic [PHASE_W-1:0]    r_phaseAcc;
    logic [LUT_ADDR_W-1:0] r_lutAddr;
    logic                  r_negS1;
    logic                  r_negS2;
    logic [DATA_W-1:0]     r_nextSample;

    logic [PHASE_W-1:0]    w_nextPhase;
    logic                  w_wrap;
    logic                  w_primeDone;
    logic                  w_advance;
    logic                  w_launch;
    logic [SEL_W-1:0]      w_launchSel;
    logic [1:0]            w_quad;
    logic [LUT_ADDR_W-1:0] w_index;
    logic [LUT_ADDR_W-1:0] w_lutAddr;
    logic [AMP_W-1:0]      w_amp;
    logic [DATA_W-1:0]     w_ampExt;

    assign w_nextPhase = r_phaseAcc + tune_word;
    assign w_wrap      = (r_state == RUN) && (r_pcnt == '1);
    assign w_primeDone = (r_state == PRIME) && (r_primeCnt == PRIME_LAST);
    assign w_advance   = enable && (w_wrap || w_primeDone);
    assign w_launch    = w_advance || (enable && (r_state == IDLE));

    // A strobe edge launches the phase it is storing, so the pipeline always
    // works one sample ahead of out_val.
    assign w_launchSel = w_advance ? w_nextPhase[PHASE_W-1 -: SEL_W]
                                   : r_phaseAcc[PHASE_W-1 -: SEL_W];
    assign w_quad      = w_launchSel[SEL_W-1 -: 2];
    assign w_index     = w_launchSel[LUT_ADDR_W-1:0];
    assign w_lutAddr   = w_quad[0] ? ~w_index : w_index;
    assign w_ampExt    = DATA_W'(w_amp);

    sine_quarter_lut #(
        .LUT_ADDR_W (LUT_ADDR_W)
    ) u_lut (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_addr  (r_lutAddr),
        .o_amp   (w_amp)
    );

    // Stage 1 holds the launched address until the next launch, so the result
    // settles in r_nextSample two edges later and stays put for the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lutAddr    <= '0;
            r_negS1      <= 1'b0;
            r_negS2      <= 1'b0;
            r_nextSample <= '0;
        end else begin
            if (w_launch) begin
                r_lutAddr <= w_lutAddr;
                r_negS1   <= w_quad[1];
            end
            r_negS2      <= r_negS1;
            r_nextSample <= r_negS2 ? (MID_LO - w_ampExt) : (MID_HI + w_ampExt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_primeCnt    <= '0;
            r_pcnt        <= '0;
            r_phaseAcc    <= '0;
            out_val       <= MID_HI;
            valid         <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            if (!enable) begin
                r_state    <= IDLE;
                r_primeCnt <= '0;
                r_pcnt     <= '0;
                valid      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= PRIME;
                        r_primeCnt <= '0;
                    end
                    PRIME: begin
                        if (r_primeCnt == PRIME_LAST) begin
                            r_state       <= RUN;
                            r_pcnt        <= '0;
                            r_phaseAcc    <= w_nextPhase;
                            out_val       <= r_nextSample;
                            valid         <= 1'b1;
                            sample_strobe <= 1'b1;
                        end else begin
                            r_primeCnt <= r_primeCnt + 2'd1;
                        end
                    end
                    RUN: begin
                        r_pcnt <= r_pcnt + 1'b1;
                        if (w_wrap) begin
                            r_phaseAcc    <= w_nextPhase;
                            out_val       <= r_nextSample;
                            sample_strobe <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        valid   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
